// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared types, round counts and helpers for the AES round scheduler
package aes_pkg;

   typedef enum logic [1:0] {
      K128 = 2'd0,
      K192 = 2'd1,
      K256 = 2'd2
   } key_len_t;

   localparam logic [3:0] NR_128 = 4'd10;
   localparam logic [3:0] NR_192 = 4'd12;
   localparam logic [3:0] NR_256 = 4'd14;

   typedef struct packed {
      logic       occ;
      logic [3:0] r;
   } slot_t;

   typedef enum logic [2:0] {
      ACT_BUBBLE,
      ACT_LOAD,
      ACT_RECIRC,
      ACT_RETIRE,
      ACT_STALL,
      ACT_KILL
   } head_act_t;

   // The unused key_len encoding falls back to AES-128.
   function automatic logic [3:0] nr_of(input key_len_t k);
      case (k)
         K192:    return NR_192;
         K256:    return NR_256;
         default: return NR_128;
      endcase
   endfunction

endpackage

// File: rtl/aes_round_sched_if.sv
// rtl/aes_round_sched_if.sv - block handshake between input FIFO, scheduler and output FIFO
interface aes_round_sched_if;

   logic i_in_valid;
   logic o_in_ready;
   logic o_out_valid;
   logic i_out_ready;

   modport master (
      output i_in_valid,
      output i_out_ready,
      input  o_in_ready,
      input  o_out_valid
   );

   modport slave (
      input  i_in_valid,
      input  i_out_ready,
      output o_in_ready,
      output o_out_valid
   );

endinterface

// File: rtl/aes_slot_ring.sv
// rtl/aes_slot_ring.sv - DEPTH-entry slot shift register mirroring the datapath round loop
module aes_slot_ring
   import aes_pkg::*;
#(
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             i_clr,
   input  logic             i_en,
   input  slot_t            i_tail,
   output slot_t            o_head,
   output logic [DEPTH-1:0] o_occ
);

   slot_t r_slots [DEPTH];

   always_ff @(posedge clk) begin
      if (i_clr) begin
         for (int i = 0; i < DEPTH; i++) r_slots[i] <= '0;
      end else if (i_en) begin
         r_slots[0] <= i_tail;
         for (int i = 1; i < DEPTH; i++) r_slots[i] <= r_slots[i-1];
      end
   end

   always_comb begin
      o_occ = '0;
      for (int i = 0; i < DEPTH; i++) o_occ[i] = r_slots[i].occ;
   end

   assign o_head = r_slots[DEPTH-1];

endmodule

// File: rtl/aes_round_sched.sv
// rtl/aes_round_sched.sv - iterative AES round loop scheduler (load/recirculate/retire)
// Optional performance counters under AES_ROUND_SCHED_PERF_EN.
module aes_round_sched
   import aes_pkg::*;
#(
   parameter int DEPTH = 1
`ifdef AES_ROUND_SCHED_PERF_EN
   ,
   parameter int CNT_W = 16
`endif
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             i_key_len,
   aes_round_sched_if.slave       hs,
   output logic                   o_load,
   output logic [3:0]             o_round_idx,
   output logic                   o_last_round,
   output logic                   o_pipe_en,
   input  logic                   i_flush,
   output logic                   o_idle,
   output logic [2:0]             o_inflight
`ifdef AES_ROUND_SCHED_PERF_EN
   ,
   output logic [CNT_W-1:0]       o_blocks_done,
   output logic [CNT_W-1:0]       o_stall_cycles
`endif
);

   logic [3:0]       r_cfg_nr;
   slot_t            w_head;
   slot_t            w_tail;
   logic [DEPTH-1:0] w_occ;
   logic             w_kill;
   logic             w_done;
   logic [3:0]       w_next_r;
   logic             w_ring_en;
   head_act_t        w_act;

   aes_slot_ring #(.DEPTH(DEPTH)) u_ring (
      .clk    (clk),
      .i_clr  (w_kill),
      .i_en   (w_ring_en),
      .i_tail (w_tail),
      .o_head (w_head),
      .o_occ  (w_occ)
   );

   assign w_kill   = reset | i_flush;
   assign w_done   = w_head.occ && (w_head.r == r_cfg_nr);
   assign w_next_r = w_head.r + 4'd1;

   // A retiring head that is accepted frees the slot for a same-cycle load.
   always_comb begin
      w_act = ACT_BUBBLE;
      if (w_kill)                             w_act = ACT_KILL;
      else if (w_done && !hs.i_out_ready)     w_act = ACT_STALL;
      else if (w_head.occ && !w_done)         w_act = ACT_RECIRC;
      else if (hs.i_in_valid)                 w_act = ACT_LOAD;
      else if (w_done)                        w_act = ACT_RETIRE;
   end

   always_comb begin
      o_load        = 1'b0;
      hs.o_in_ready = 1'b0;
      o_round_idx   = 4'd0;
      o_last_round  = 1'b0;
      w_tail        = '0;
      case (w_act)
         ACT_LOAD: begin
            o_load        = 1'b1;
            hs.o_in_ready = 1'b1;
            o_round_idx   = 4'd1;
            w_tail.occ    = 1'b1;
            w_tail.r      = 4'd1;
         end
         ACT_RECIRC: begin
            o_round_idx  = w_next_r;
            o_last_round = (w_next_r == r_cfg_nr);
            w_tail.occ   = 1'b1;
            w_tail.r     = w_next_r;
         end
         default: ;
      endcase
   end

   assign hs.o_out_valid = w_done & ~w_kill;
   assign w_ring_en      = (w_act != ACT_STALL);
   assign o_pipe_en      = ~reset & w_ring_en;

   // Round count only follows the key length while the loop is empty.
   always_ff @(posedge clk) begin
      if (reset)       r_cfg_nr <= NR_128;
      else if (o_idle) r_cfg_nr <= nr_of(key_len_t'(i_key_len));
   end

   always_comb begin
      o_inflight = '0;
      for (int i = 0; i < DEPTH; i++) o_inflight = o_inflight + 3'(w_occ[i]);
   end

   assign o_idle = (o_inflight == 3'd0);

`ifdef AES_ROUND_SCHED_PERF_EN
   logic [CNT_W-1:0] r_blocks_done;
   logic [CNT_W-1:0] r_stall_cycles;

   always_ff @(posedge clk) begin
      if (w_kill) begin
         r_blocks_done  <= '0;
         r_stall_cycles <= '0;
      end else begin
         if (hs.o_out_valid && hs.i_out_ready && (r_blocks_done != '1))
            r_blocks_done <= r_blocks_done + CNT_W'(1);
         if (!o_pipe_en && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
   end

   assign o_blocks_done  = r_blocks_done;
   assign o_stall_cycles = r_stall_cycles;
`endif

endmodule
